dma_audio_engine: RTL
=====================

Name: dma_audio_engine

Overview:
- Parametrised successor to the shifter's built-in STE DMA-sound path. Buffers sample words fetched by the MCU DMA (SLOAD_N strobes on the RAM bus) in a configurable-depth FIFO.
- Paces playback from a clk32-derived base tick and formats 8-bit stereo, 8-bit mono or 16-bit stereo samples into two 16-bit offset-binary channel outputs.
- Adds full-depth FIFO use, a programmable request watermark, flush, and sticky underrun/overflow status.
- Sits beside gstshifter: the shifter register file drives mode/enable/flush; SREQ goes to the MCU.

Parameters:
- FIFO_ADDR_BITS, 3, FIFO depth = 2^FIFO_ADDR_BITS words (all entries usable).
- SREQ_FREE, 1, SREQ asserted while free entries >= SREQ_FREE (range 1..depth).
- BASE_DIV, 640, clk32 cycles per base tick (640 gives 50 kHz at 32 MHz).

Ports:
- clk32  in  1  system clock, 32 MHz.
- resb  in  1  asynchronous active-low reset.
- SLOAD_N  in  1  DMA sound load strobe; MDIN is valid on its falling edge.
- MDIN  in  16  RAM data bus.
- enable  in  1  playback enable (DMA sound control bit 0).
- flush  in  1  synchronous single-cycle FIFO/state clear.
- rate  in  2  3=50k, 2=25k, 1=12.5k, 0=6.25 kHz (base tick divided by 1/2/4/8).
- fmt  in  2  0=8-bit stereo, 1=8-bit mono, 2=16-bit stereo, 3=reserved (treated as 0).
- SREQ  out  1  sound DMA request.
- audio_left  out  16  left sample, offset binary.
- audio_right  out  16  right sample, offset binary.
- level  out  FIFO_ADDR_BITS+1  words currently in FIFO.
- underrun  out  1  sticky: a tick found insufficient data.
- overflow  out  1  sticky: a load arrived while FIFO full.

Behaviour:
- Reset (async, resb low): pointers, level, divider counters, bytesel and phase = 0; audio_left/right = 16'h8000; underrun = overflow = 0; SREQ = 1.
- Pointers are FIFO_ADDR_BITS+1 bits wide; level = wp - rp; full when level == depth; empty when level == 0.
- Load: sload_d registers SLOAD_N. When sload_d & ~SLOAD_N: if not full, write MDIN at wp[FIFO_ADDR_BITS-1:0] and increment wp; if full, drop the word and set overflow.
- SREQ = (depth - level) >= SREQ_FREE, combinational from the registered pointers.
- Base counter runs 0..BASE_DIV-1 continuously. base_tick is high in the cycle the counter equals BASE_DIV-1.
- The 3-bit rate counter increments on base_tick while enable = 1 and is held at 0 while enable = 0.
- tick = base_tick & enable & (rate counter bits selected by rate are all zero). The first tick therefore occurs on the first base_tick after enable rises.
- On tick, with outputs registered on the same edge:
  - fmt 0: needs 1 word w. L = {w[15:8]^8'h80, 8'h00}, R = {w[7:0]^8'h80, 8'h00}. rp += 1.
  - fmt 1: needs 1 word. bytesel = 0 selects w[15:8], 1 selects w[7:0]. L = R = {byte^8'h80, 8'h00}. bytesel toggles; rp += 1 only when bytesel was 1.
  - fmt 2: needs 2 words (L word first). L = w0^16'h8000, R = w1^16'h8000, updated together; rp += 2.
- Insufficient data at a tick: outputs hold, rp unchanged, underrun set.
- A load and a consume in the same cycle both take effect; level changes by the net amount.
- bytesel is cleared whenever fmt != 1.
- fmt/rate are sampled at each tick; changing them mid-stream is allowed, with no extra flush.
- flush, or a rising edge of enable: rp = wp = 0, bytesel = 0, and underrun/overflow cleared. flush also sets outputs to 16'h8000. flush has priority over a simultaneous load, which is discarded.
- underrun/overflow are cleared only by reset, flush or an enable rising edge.

Decomposition:
- Shared package audio_pkg:
  - rate codes RATE_50K/25K/12K5/6K25;
  - fmt codes FMT_S8/M8/S16;
  - MIDSCALE = 16'h8000.
- Sub-module audio_fifo, parametrised by FIFO_ADDR_BITS:
  - write port;
  - two-word lookahead read (rd0 = fifo[rp], rd1 = fifo[rp+1]);
  - pop-by-0/1/2;
  - level output.

Test Plan:
- Reset then idle (BASE_DIV=8) -> audio_left = audio_right = 16'h8000, SREQ = 1, level = 0, flags 0.
- fmt 0, rate 3: load 16'h1234, enable -> at first tick L = 16'h9200, R = 16'hB400, level 1 -> 0.
- fmt 1: load 16'hFF01 -> tick 1 gives L = R = 16'h7F00; tick 2 gives L = R = 16'h8100; rp advances only after tick 2.
- fmt 2: load only 16'h0001 -> tick sets underrun with outputs held. Load 16'hFFFF -> next tick L = 16'h8001, R = 16'h7FFF.
- FIFO_ADDR_BITS=3, SREQ_FREE=2, enable 0: 7 loads -> SREQ falls after the 7th. 8th load gives level 8; 9th sets overflow with level still 8.
- flush asserted in the same cycle as a load at level 5 -> level 0, flags cleared, outputs 16'h8000, loaded word discarded.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared rate/format codes and sample helpers for the DMA audio engine.
package audio_pkg;

    // Playback rate select: base tick divided by 1/2/4/8.
    typedef enum logic [1:0] {
        RATE_6K25 = 2'd0,
        RATE_12K5 = 2'd1,
        RATE_25K  = 2'd2,
        RATE_50K  = 2'd3
    } rate_e;

    // Sample format select; the reserved code plays as 8-bit stereo.
    typedef enum logic [1:0] {
        FMT_S8   = 2'd0,
        FMT_M8   = 2'd1,
        FMT_S16  = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_e;

    localparam logic [15:0] MIDSCALE = 16'h8000;

    // Rate-counter bits that must all be zero for a playback tick.
    function automatic logic [2:0] rate_mask(input logic [1:0] r);
        case (rate_e'(r))
            RATE_50K:  return 3'b000;
            RATE_25K:  return 3'b001;
            RATE_12K5: return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

    // Signed 8-bit sample to 16-bit offset binary.
    function automatic logic [15:0] byte_sample(input logic [7:0] b);
        return {b ^ 8'h80, 8'h00};
    endfunction

endpackage

// File: rtl/dma_audio_engine_if.sv
// RAM-bus side of the sound DMA: load strobe, data bus and request.
interface dma_audio_engine_if;
    logic        SLOAD_N;
    logic [15:0] MDIN;
    logic        SREQ;

    // MCU/DMA side drives loads and watches the request.
    modport master (
        output SLOAD_N,
        output MDIN,
        input  SREQ
    );

    // Audio engine side.
    modport slave (
        input  SLOAD_N,
        input  MDIN,
        output SREQ
    );
endinterface

// File: rtl/audio_fifo.sv
// Sample-word FIFO with two-word lookahead and pop-by-0/1/2.
// Pointers carry one extra bit so all 2^FIFO_ADDR_BITS entries are usable.
module audio_fifo #(
    parameter int unsigned FIFO_ADDR_BITS = 3
) (
    input  logic                    clk32,
    input  logic                    resb,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [15:0]             wr_data,
    input  logic [1:0]              pop,
    output logic [15:0]             rd0,
    output logic [15:0]             rd1,
    output logic [FIFO_ADDR_BITS:0] level,
    output logic                    full
);
    localparam int unsigned AW    = FIFO_ADDR_BITS;
    localparam int unsigned PW    = FIFO_ADDR_BITS + 1;
    localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic [PW-1:0] rp_next;
    logic          push;

    assign level   = wp_q - rp_q;
    assign full    = (level == DEPTH_W);
    // A word offered while full is dropped; clear discards a same-cycle write.
    assign push    = wr_en & ~full & ~clear;
    assign rp_next = rp_q + 1'b1;
    assign rd0     = mem[rp_q[AW-1:0]];
    assign rd1     = mem[rp_next[AW-1:0]];

    // Read/write pointer update; consumer never pops during clear.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (clear) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
            end
            rp_q <= rp_q + PW'(pop);
        end
    end

    // Storage array write.
    always_ff @(posedge clk32) begin
        if (push) begin
            mem[wp_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/dma_audio_engine.sv
// DMA sound engine: buffers DMA-loaded words, paces playback from clk32
// and formats 8-bit stereo/mono or 16-bit stereo into offset-binary outputs.
module dma_audio_engine
    import audio_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_BITS = 3,
    parameter int unsigned SREQ_FREE      = 1,
    parameter int unsigned BASE_DIV       = 640
) (
    input  logic                    clk32,
    input  logic                    resb,
    dma_audio_engine_if.slave       bus,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [1:0]              rate,
    input  logic [1:0]              fmt,
    output logic [15:0]             audio_left,
    output logic [15:0]             audio_right,
    output logic [FIFO_ADDR_BITS:0] level,
    output logic                    underrun,
    output logic                    overflow
);
    localparam int unsigned LW     = FIFO_ADDR_BITS + 1;
    localparam int unsigned DEPTH  = 1 << FIFO_ADDR_BITS;
    localparam int unsigned BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [LW-1:0]     DEPTH_W     = LW'(DEPTH);
    localparam logic [LW-1:0]     SREQ_FREE_W = LW'(SREQ_FREE);
    localparam logic [LW-1:0]     ONE_W       = LW'(1);
    localparam logic [LW-1:0]     TWO_W       = LW'(2);
    localparam logic [BASE_W-1:0] BASE_LAST   = BASE_W'(BASE_DIV - 1);

    logic              sload_q;
    logic              enable_q;
    logic              load;
    logic              enable_rise;
    logic              clear;
    logic [BASE_W-1:0] base_cnt_q;
    logic              base_tick;
    logic [2:0]        rate_cnt_q;
    logic              tick;
    fmt_e              fmt_cur;
    logic [1:0]        pop;
    logic [15:0]       left_d;
    logic [15:0]       right_d;
    logic              bytesel_q;
    logic              bytesel_d;
    logic              underrun_set;
    logic              full;
    logic [15:0]       rd0;
    logic [15:0]       rd1;

    assign load        = sload_q & ~bus.SLOAD_N;
    assign enable_rise = enable & ~enable_q;
    assign clear       = flush | enable_rise;
    assign base_tick   = (base_cnt_q == BASE_LAST);
    assign tick        = base_tick & enable & ~|(rate_cnt_q & rate_mask(rate));
    assign fmt_cur     = (fmt_e'(fmt) == FMT_RSVD) ? FMT_S8 : fmt_e'(fmt);
    assign bus.SREQ    = (DEPTH_W - level) >= SREQ_FREE_W;

    audio_fifo #(
        .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk32   (clk32),
        .resb    (resb),
        .clear   (clear),
        .wr_en   (load),
        .wr_data (bus.MDIN),
        .pop     (pop),
        .rd0     (rd0),
        .rd1     (rd1),
        .level   (level),
        .full    (full)
    );

    // Edge detectors for the load strobe and the enable bit.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            sload_q  <= 1'b1;
            enable_q <= 1'b0;
        end else begin
            sload_q  <= bus.SLOAD_N;
            enable_q <= enable;
        end
    end

    // Free-running base divider, 0..BASE_DIV-1.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            base_cnt_q <= '0;
        end else if (base_tick) begin
            base_cnt_q <= '0;
        end else begin
            base_cnt_q <= base_cnt_q + 1'b1;
        end
    end

    // Rate sub-divider: held at zero while disabled so the first base tick plays.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            rate_cnt_q <= '0;
        end else if (!enable) begin
            rate_cnt_q <= '0;
        end else if (base_tick) begin
            rate_cnt_q <= rate_cnt_q + 3'd1;
        end
    end

    // Sample formatting and FIFO consumption at a playback tick.
    always_comb begin
        pop          = 2'd0;
        left_d       = audio_left;
        right_d      = audio_right;
        bytesel_d    = (fmt_cur == FMT_M8) ? bytesel_q : 1'b0;
        underrun_set = 1'b0;
        if (tick && !clear) begin
            case (fmt_cur)
                FMT_S16: begin
                    if (level >= TWO_W) begin
                        left_d  = rd0 ^ MIDSCALE;
                        right_d = rd1 ^ MIDSCALE;
                        pop     = 2'd2;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
                FMT_M8: begin
                    if (level >= ONE_W) begin
                        left_d    = byte_sample(bytesel_q ? rd0[7:0] : rd0[15:8]);
                        right_d   = left_d;
                        bytesel_d = ~bytesel_q;
                        // Word retires only once its low byte has played.
                        pop       = bytesel_q ? 2'd1 : 2'd0;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
                default: begin
                    if (level >= ONE_W) begin
                        left_d  = byte_sample(rd0[15:8]);
                        right_d = byte_sample(rd0[7:0]);
                        pop     = 2'd1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered outputs, byte select and sticky status.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            audio_left  <= MIDSCALE;
            audio_right <= MIDSCALE;
            bytesel_q   <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            bytesel_q <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
            // Enable rising alone keeps the last sample on the outputs.
            if (flush) begin
                audio_left  <= MIDSCALE;
                audio_right <= MIDSCALE;
            end
        end else begin
            audio_left  <= left_d;
            audio_right <= right_d;
            bytesel_q   <= bytesel_d;
            underrun    <= underrun | underrun_set;
            overflow    <= overflow | (load & full);
        end
    end

endmodule
